// File: rtl/frame_pixel_fetch.sv
// rtl/frame_pixel_fetch.sv - frame BRAM walker unpacking two RGB pixels per word into the pixel FIFO
// Define TEST_PATTERN_EN to replace BRAM pixels with eight vertical colour bars.
module frame_pixel_fetch #(
   parameter int ADDR_W      = 16,
   parameter int FRAME_WORDS = 38400,
   parameter int H_PIX       = 320
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_full,
   input  logic [63:0]       data_rd,
   input  logic              done,
   output logic [ADDR_W-1:0] mem_data_addr,
   output logic [23:0]       data_out,
   output logic              WEN,
   output logic              last_addr_update
);

   typedef enum logic [2:0] {IDLE, ADDR, LATCH, PIX_LO, PIX_HI} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   state_t state_q, state_d;
   logic   at_last;
   logic   frame_end;

   assign at_last   = (mem_data_addr == LAST_ADDR);
   assign frame_end = (state_q == PIX_HI) && WEN && at_last;

   always_comb begin
      state_d = state_q;
      WEN     = 1'b0;
      case (state_q)
         IDLE:   if (!done) state_d = ADDR;
         ADDR:   state_d = LATCH;
         LATCH:  state_d = PIX_LO;
         PIX_LO: begin
            WEN = ~fifo_full;
            if (!fifo_full) state_d = PIX_HI;
         end
         PIX_HI: begin
            WEN = ~fifo_full;
            // done only matters on the write that closes the frame
            if (!fifo_full) state_d = (at_last && done) ? IDLE : ADDR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ADDR;
         mem_data_addr    <= '0;
         last_addr_update <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_addr_update <= frame_end;
         if (state_q == IDLE)
            mem_data_addr <= '0;
         else if (state_q == PIX_HI && WEN)
            mem_data_addr <= at_last ? '0 : mem_data_addr + 1'b1;
      end
   end

`ifdef TEST_PATTERN_EN
   localparam int X_W   = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int BAR_W = (H_PIX >= 8) ? H_PIX / 8 : 1;

   logic [X_W-1:0] x_q;
   logic [2:0]     bar;
   logic [23:0]    colour;
   logic           unused_rd;

   assign unused_rd = ^data_rd;
   assign bar       = 3'(32'(x_q) / BAR_W);

   // Column counter advances only on a write, so a stalled pixel keeps its colour
   always_ff @(posedge clk) begin
      if (rst)
         x_q <= '0;
      else if (WEN)
         x_q <= (frame_end || x_q == X_W'(H_PIX - 1)) ? '0 : x_q + 1'b1;
   end

   always_comb begin
      colour = 24'h000000;
      case (bar)
         3'd0: colour = 24'hFFFFFF;
         3'd1: colour = 24'hFFFF00;
         3'd2: colour = 24'h00FFFF;
         3'd3: colour = 24'h00FF00;
         3'd4: colour = 24'hFF00FF;
         3'd5: colour = 24'hFF0000;
         3'd6: colour = 24'h0000FF;
         default: colour = 24'h000000;
      endcase
   end

   assign data_out = (state_q == PIX_LO || state_q == PIX_HI) ? colour : 24'h000000;
`else
   logic [47:0] word_q;
   logic        unused_rd;

   // Bytes [31:24] and [63:56] of each BRAM word carry no pixel data
   assign unused_rd = ^{data_rd[63:56], data_rd[31:24]};

   always_ff @(posedge clk) begin
      if (rst)
         word_q <= '0;
      else if (state_q == LATCH)
         word_q <= {data_rd[55:32], data_rd[23:0]};
   end

   assign data_out = (state_q == PIX_HI) ? word_q[47:24] : word_q[23:0];
`endif

endmodule

// File: tb/tb_frame_pixel_fetch.sv
// tb/tb_frame_pixel_fetch.sv - self-checking bench for frame_pixel_fetch with a pixel-stream reference model
module tb_frame_pixel_fetch;

   localparam int ADDR_W = 16;
   localparam int FW     = 8;
   localparam int HP     = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              fifo_full = 1'b0;
   logic [63:0]       data_rd = '0;
   logic              done = 1'b0;
   logic [ADDR_W-1:0] mem_data_addr;
   logic [23:0]       data_out;
   logic              WEN;
   logic              last_addr_update;

   frame_pixel_fetch #(.ADDR_W(ADDR_W), .FRAME_WORDS(FW), .H_PIX(HP)) dut (
      .clk(clk), .rst(rst), .fifo_full(fifo_full), .data_rd(data_rd), .done(done),
      .mem_data_addr(mem_data_addr), .data_out(data_out), .WEN(WEN),
      .last_addr_update(last_addr_update)
   );

   always #5 clk = ~clk;

   logic [63:0] mem [FW];
   always @(posedge clk) data_rd <= mem[mem_data_addr[2:0]];

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [23:0] exp_pix(input int p);
`ifdef TEST_PATTERN_EN
      case ((p % HP) / (HP / 8))
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
`else
      logic [63:0] w;
      w = mem[p / 2];
      return (p % 2 == 1) ? w[55:32] : w[23:0];
`endif
   endfunction

   // Reference model: index of the next pixel of the frame, cycles until it may be
   // written, parked-at-frame-end flag, and a pending frame-end pulse.
   int m_p = 0;
   int m_wait = 3;
   bit m_parked = 0;
   bit m_last = 0;

   always @(negedge clk) begin
      bit ready, exp_wen, exp_last;
      if (rst) begin
         m_p = 0; m_wait = 3; m_parked = 0; m_last = 0;
      end else begin
         exp_last = m_last;
         m_last   = 0;
         if (m_wait > 0) m_wait--;
         ready   = (m_wait == 0) && !m_parked;
         exp_wen = ready && !fifo_full;
         check("wen", WEN, exp_wen);
         check("last_addr_update", last_addr_update, exp_last);
         check("addr", mem_data_addr, m_p / 2);
         if (ready) check("data_out", data_out, exp_pix(m_p));
         if (WEN && exp_wen) begin
            if (m_p % 2 == 1) begin
               if (m_p == 2 * FW - 1) begin
                  m_last = 1; m_p = 0;
                  if (done) m_parked = 1;
               end else begin
                  m_p++;
               end
               m_wait = 3;
            end else begin
               m_p++;
            end
         end else if (m_parked && !done) begin
            m_parked = 0; m_wait = 3;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   logic [23:0] lit_pix [4];
   logic [23:0] lit_p10;
   bit          wen_pat [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

   initial begin
      int k;
      logic [23:0] got [2];
      int ng;
      for (int i = 0; i < FW; i++) mem[i] = {8'h0, 24'(2 * i + 1), 8'h0, 24'(2 * i)};
`ifdef TEST_PATTERN_EN
      lit_pix = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00};
      lit_p10 = 24'hFF0000;
      check("model_pin_p2", exp_pix(2), 24'hFFFF00);
      check("model_pin_p15", exp_pix(15), 24'h000000);
`else
      lit_pix = '{24'd0, 24'd1, 24'd2, 24'd3};
      lit_p10 = 24'd10;
      check("model_pin_p5", exp_pix(5), 24'd5);
      check("model_pin_p14", exp_pix(14), 24'd14);
`endif

      // reset state and fixed WEN cadence
      rst = 1'b1; tick(); tick();
      check("reset_addr", mem_data_addr, 0);
      check("reset_wen", WEN, 0);
      check("reset_last", last_addr_update, 0);
      rst = 1'b0;
      ng = 0;
      for (int i = 0; i < 8; i++) begin
         sample();
         check("wen_cadence", WEN, wen_pat[i]);
         if (WEN && ng < 4) begin
            check("first_pixels", data_out, lit_pix[ng]);
            ng++;
         end
      end

      // long stall around pixel 10
      k = 0;
      while (m_p != 10 && k < 100) begin sample(); k++; end
      check("reach_p10", m_p, 10);
      tick(); fifo_full = 1'b1;
      repeat (12) tick();
      fifo_full = 1'b0;
      ng = 0;
      for (int i = 0; i < 20 && ng < 2; i++) begin
         sample();
         if (WEN) begin got[ng] = data_out; ng++; end
      end
      check("after_stall_0", got[0], lit_p10);
      check("after_stall_1", got[1], exp_pix(11));

      // frame wrap pulse
      k = 0;
      do begin sample(); k++; end while (!last_addr_update && k < 200);
      check("last_seen", last_addr_update, 1);
      check("wrap_addr", mem_data_addr, 0);
      sample();
      check("last_one_cycle", last_addr_update, 0);

      // park at frame boundary
      k = 0;
      while (m_p != 2 && k < 100) begin sample(); k++; end
      tick(); done = 1'b1;
      k = 0;
      while (!m_parked && k < 200) begin sample(); k++; end
      check("parked", m_parked, 1);
      for (int i = 0; i < 5; i++) begin
         sample();
         check("idle_wen", WEN, 0);
         check("idle_addr", mem_data_addr, 0);
      end
      tick(); done = 1'b0;
      k = 0;
      for (k = 0; k < 10; k++) begin
         sample();
         if (WEN) break;
      end
      check("unpark_latency", k, 3);
      check("unpark_pixel", data_out, lit_pix[0]);

      // reset while in PIX_HI of word 3
      k = 0;
      while (m_p != 7 && k < 100) begin sample(); k++; end
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      sample();
      check("post_rst_wen", WEN, 0);
      check("post_rst_addr", mem_data_addr, 0);
      k = 0;
      while (!WEN && k < 20) begin sample(); k++; end
      check("post_rst_pixel", data_out, lit_pix[0]);

      // randomized traffic with random BRAM contents
      tick(); rst = 1'b1;
      for (int i = 0; i < FW; i++) mem[i] = {$urandom, $urandom};
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         fifo_full = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 149) == 0) done = ~done;
         rst = ($urandom_range(0, 599) == 0);
      end
      tick(); rst = 1'b0; fifo_full = 1'b0; done = 1'b0;
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
